// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and fetch-qualification unit.
//
// Produces the instruction-memory fetch address and handles redirects
// (jump, taken branch), stalls and halt. A one-cycle BUBBLE follows every
// redirect, squashing the instruction already in flight from the
// synchronous-read instruction memory.
//
// Ports:
//   clock          system clock, rising-edge active
//   reset          asynchronous active-low reset
//   stall          hold pc and state; no valid fetch this cycle
//   branch_taken   redirect to branch_base + branch_offset (mod 4096)
//   branch_base    pc+1 of the resolved branch
//   branch_offset  two's-complement displacement
//   jump           redirect to jump_target (J/JAL/JR, target muxed upstream)
//   jump_target    absolute jump address
//   halt_req       stop fetching until reset
//   pc             current fetch address
//   pc_plus1       (pc + 1) mod 4096, combinational
//   fetch_valid    returned instruction is architecturally valid
//   halted         block is in HALT
//   fetch_count    saturating count of cycles with fetch_valid=1
module pc_fetch (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [11:0] branch_base,
   input  logic [11:0] branch_offset,
   input  logic        jump,
   input  logic [11:0] jump_target,
   input  logic        halt_req,
   output logic [11:0] pc,
   output logic [11:0] pc_plus1,
   output logic        fetch_valid,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {StRun, StBubble, StHalt} state_e;

   state_e      state_q;
   // Set only by reset: the bubble that follows reset moves to RUN without
   // advancing pc, so address 0x000 is fetched first. Redirect bubbles do
   // advance pc on exit.
   logic        boot_q;
   logic [11:0] branch_target;

   assign pc_plus1      = pc + 12'd1;
   assign branch_target = branch_base + branch_offset;  // carry discarded
   assign fetch_valid   = (state_q == StRun) && !stall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc          <= 12'h000;
         state_q     <= StBubble;
         boot_q      <= 1'b1;
         halted      <= 1'b0;
         fetch_count <= 16'h0000;
      end else begin
         if (fetch_valid && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
         end

         unique case (state_q)
            StRun, StBubble: begin
               if (halt_req) begin
                  state_q <= StHalt;
                  halted  <= 1'b1;
               end else if (jump) begin
                  pc      <= jump_target;
                  state_q <= StBubble;
                  boot_q  <= 1'b0;
               end else if (branch_taken) begin
                  pc      <= branch_target;
                  state_q <= StBubble;
                  boot_q  <= 1'b0;
               end else if (stall) begin
                  // hold pc, state and boot flag
               end else begin
                  if (!(state_q == StBubble && boot_q)) begin
                     pc <= pc_plus1;
                  end
                  state_q <= StRun;
                  boot_q  <= 1'b0;
               end
            end
            default: begin
               // HALT: only reset leaves it
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_pc_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [11:0] branch_base = '0;
   logic [11:0] branch_offset = '0;
   logic        jump = 1'b0;
   logic [11:0] jump_target = '0;
   logic        halt_req = 1'b0;
   logic [11:0] pc;
   logic [11:0] pc_plus1;
   logic        fetch_valid;
   logic        halted;
   logic [15:0] fetch_count;

   int checks = 0;
   int failures = 0;

   pc_fetch dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_base  (branch_base),
      .branch_offset(branch_offset),
      .jump         (jump),
      .jump_target  (jump_target),
      .halt_req     (halt_req),
      .pc           (pc),
      .pc_plus1     (pc_plus1),
      .fetch_valid  (fetch_valid),
      .halted       (halted),
      .fetch_count  (fetch_count)
   );

   always #5 clock = ~clock;

   // Reference model: mode 0 = running, 1 = bubble, 2 = halted.
   localparam int MRun = 0, MBubble = 1, MHalt = 2;
   int          m_mode;
   int unsigned m_pc;
   int unsigned m_count;
   bit          m_after_reset;

   function automatic bit m_fv();
      return (m_mode == MRun) && !stall;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_mode = MBubble; m_count = 0; m_after_reset = 1;
   endtask

   // Applies the next-pc rules in priority order to the inputs seen at an edge.
   task automatic model_edge();
      if (m_fv() && m_count < 65535) m_count++;
      if (m_mode == MHalt) begin
      end else if (halt_req) begin
         m_mode = MHalt;
      end else if (jump) begin
         m_pc = int'(jump_target); m_mode = MBubble; m_after_reset = 0;
      end else if (branch_taken) begin
         m_pc = (int'(branch_base) + int'(branch_offset)) % 4096;
         m_mode = MBubble; m_after_reset = 0;
      end else if (stall) begin
      end else begin
         if (!(m_mode == MBubble && m_after_reset)) m_pc = (m_pc + 1) % 4096;
         m_mode = MRun; m_after_reset = 0;
      end
   endtask

   task automatic idle();
      stall = 0; branch_taken = 0; jump = 0; halt_req = 0;
      branch_base = '0; branch_offset = '0; jump_target = '0;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      #7;
      checks++; if (pc !== 12'h000) begin failures++; $display("FAIL rst_pc got=%h want=000", pc); end
      checks++; if (pc_plus1 !== 12'h001) begin failures++; $display("FAIL rst_pc_plus1 got=%h want=001", pc_plus1); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b want=0", halted); end
      checks++; if (fetch_count !== 16'h0000) begin failures++; $display("FAIL rst_count got=%h want=0000", fetch_count); end
      checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fv got=%b want=0", fetch_valid); end
   endtask

   task automatic test_reset_release();
      int exp_pc[5];
      int exp_fv[5];
      exp_pc = '{0, 0, 1, 2, 3};
      exp_fv = '{0, 1, 1, 1, 1};
      idle();
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++; if (pc !== exp_pc[i][11:0]) begin failures++; $display("FAIL release_pc[%0d] got=%h want=%h", i, pc, exp_pc[i][11:0]); end
         checks++; if (fetch_valid !== exp_fv[i][0]) begin failures++; $display("FAIL release_fv[%0d] got=%b want=%b", i, fetch_valid, exp_fv[i][0]); end
      end
      step();
      checks++; if (fetch_count !== 16'd4) begin failures++; $display("FAIL release_count got=%0d want=4", fetch_count); end
   endtask

   task automatic test_wrap();
      jump = 1; jump_target = 12'hFFE;
      step(); idle();
      checks++; if (pc !== 12'hFFE || fetch_valid !== 1'b0) begin failures++; $display("FAIL wrap_ffe got=%h/%b want=ffe/0", pc, fetch_valid); end
      step();
      checks++; if (pc !== 12'hFFF || fetch_valid !== 1'b1) begin failures++; $display("FAIL wrap_fff got=%h/%b want=fff/1", pc, fetch_valid); end
      checks++; if (pc_plus1 !== 12'h000) begin failures++; $display("FAIL wrap_plus1 got=%h want=000", pc_plus1); end
      step();
      checks++; if (pc !== 12'h000 || fetch_valid !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL wrap_000 got=%h/%b/%b want=000/1/0", pc, fetch_valid, halted); end
   endtask

   task automatic test_branch();
      jump = 1; jump_target = 12'h00F;
      step(); idle(); step();
      checks++; if (pc !== 12'h010 || fetch_valid !== 1'b1) begin failures++; $display("FAIL br_setup got=%h/%b want=010/1", pc, fetch_valid); end
      branch_taken = 1; branch_base = 12'h00A; branch_offset = 12'hFFC;
      step(); idle();
      checks++; if (pc !== 12'h006 || fetch_valid !== 1'b0) begin failures++; $display("FAIL br_target got=%h/%b want=006/0", pc, fetch_valid); end
      step();
      checks++; if (pc !== 12'h007 || fetch_valid !== 1'b1) begin failures++; $display("FAIL br_after got=%h/%b want=007/1", pc, fetch_valid); end
   endtask

   task automatic test_priority();
      jump = 1; jump_target = 12'h123; branch_taken = 1;
      branch_base = 12'h300; branch_offset = 12'h011; stall = 1;
      step(); idle();
      checks++; if (pc !== 12'h123 || fetch_valid !== 1'b0) begin failures++; $display("FAIL prio_jump got=%h/%b want=123/0", pc, fetch_valid); end
      jump = 1; jump_target = 12'h200;
      step(); idle();
      checks++; if (pc !== 12'h200 || fetch_valid !== 1'b0) begin failures++; $display("FAIL prio_rebubble got=%h/%b want=200/0", pc, fetch_valid); end
      step();
      checks++; if (pc !== 12'h201 || fetch_valid !== 1'b1) begin failures++; $display("FAIL prio_run got=%h/%b want=201/1", pc, fetch_valid); end
   endtask

   task automatic test_stall();
      jump = 1; jump_target = 12'h03F;
      step(); idle(); step();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (pc !== 12'h040 || fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d] got=%h/%b want=040/0", i, pc, fetch_valid); end
         checks++; if (fetch_count !== m_count[15:0]) begin failures++; $display("FAIL stall_count[%0d] got=%h want=%h", i, fetch_count, m_count[15:0]); end
      end
      stall = 0;
      step();
      checks++; if (pc !== 12'h041 || fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_release got=%h/%b want=041/1", pc, fetch_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         jump          = ($urandom_range(0, 7) == 0);
         jump_target   = 12'($urandom);
         branch_taken  = ($urandom_range(0, 5) == 0);
         branch_base   = 12'($urandom);
         branch_offset = 12'($urandom);
         stall         = ($urandom_range(0, 3) == 0);
         halt_req      = 0;
         step();
         checks++;
         if (pc !== m_pc[11:0] || pc_plus1 !== 12'(m_pc + 1) || fetch_valid !== m_fv()
             || halted !== (m_mode == MHalt) || fetch_count !== m_count[15:0]) begin
            failures++;
            $display("FAIL random[%0d] got pc=%h p1=%h fv=%b h=%b cnt=%h want pc=%h p1=%h fv=%b h=%b cnt=%h",
                     i, pc, pc_plus1, fetch_valid, halted, fetch_count, m_pc[11:0],
                     12'(m_pc + 1), m_fv(), (m_mode == MHalt), m_count[15:0]);
         end
      end
      idle();
   endtask

   task automatic test_reset_abort();
      jump = 1; jump_target = 12'h333;
      #3 reset = 1'b0;
      #1;
      checks++; if (pc !== 12'h000 || fetch_count !== 16'h0000) begin failures++; $display("FAIL abort_async got=%h/%h want=000/0000", pc, fetch_count); end
      @(posedge clock); #1;
      checks++; if (pc !== 12'h000 || fetch_valid !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL abort_edge got=%h/%b/%b want=000/0/0", pc, fetch_valid, halted); end
      idle();
      reset = 1'b1;
      model_reset();
      step();
      checks++; if (pc !== 12'h000 || fetch_valid !== 1'b1) begin failures++; $display("FAIL abort_restart got=%h/%b want=000/1", pc, fetch_valid); end
   endtask

   task automatic test_halt();
      jump = 1; jump_target = 12'h054;
      step(); idle(); step();
      halt_req = 1;
      step(); idle();
      checks++; if (pc !== 12'h055 || halted !== 1'b1 || fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_enter got=%h/%b/%b want=055/1/0", pc, halted, fetch_valid); end
      for (int i = 0; i < 8; i++) begin
         jump = $urandom_range(0, 1); jump_target = 12'($urandom);
         branch_taken = 1; branch_base = 12'($urandom); branch_offset = 12'($urandom);
         stall = $urandom_range(0, 1); halt_req = $urandom_range(0, 1);
         step();
         checks++; if (pc !== 12'h055 || halted !== 1'b1 || fetch_valid !== 1'b0 || fetch_count !== m_count[15:0]) begin
            failures++; $display("FAIL halt_hold[%0d] got=%h/%b/%b/%h want=055/1/0/%h", i, pc, halted, fetch_valid, fetch_count, m_count[15:0]);
         end
      end
      idle();
      #2 reset = 1'b0;
      #1;
      checks++; if (pc !== 12'h000 || halted !== 1'b0 || pc_plus1 !== 12'h001) begin failures++; $display("FAIL halt_reset got=%h/%b/%h want=000/0/001", pc, halted, pc_plus1); end
      model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_reset_release();
      test_wrap();
      test_branch();
      test_priority();
      test_stall();
      test_random();
      test_reset_abort();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
